// File: rtl/data_memory_stage.sv
// Purpose : MEM stage data memory with byte/half/word loads and stores, sign/zero extension.
// Latency : request seen in IDLE, LATENCY cycles in ACCESS, result in MemReadData during DONE.
// Backpr. : MemStall holds upstream from request acceptance through the last ACCESS cycle.
// Ports   : Clk/Reset (async, active-high); MemRead/MemWrite/MemSize/MemUnsigned/Address/WriteData
//           request inputs; MemReadData registered load result; MemStall, MisalignedExc combinational.
module data_memory_stage #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemUnsigned,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] MemReadData,
  output logic        MemStall,
  output logic        MisalignedExc
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q;
  logic [1:0]      lane_q;
  logic [31:0]     wdata_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic            wr_q;
  logic            rd_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem_q [MEM_WORDS];

  logic            req;
  logic            misaligned;
  logic            start;
  logic            fire;
  logic [31:0]     cur_word;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [31:0]     load_ext;
  logic [31:0]     store_word;

  assign req = MemRead | MemWrite;

  // Size 11 decodes as a word, so only half and byte relax the check.
  always_comb begin
    misaligned = 1'b0;
    case (MemSize)
      2'b01:   misaligned = Address[0];
      2'b10:   misaligned = 1'b0;
      default: misaligned = (Address[1:0] != 2'b00);
    endcase
  end

  assign start = (state_q == IDLE) && req && !misaligned;
  assign fire  = (state_q == ACCESS) && (cnt_q == '0);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    MemStall      = 1'b0;
    MisalignedExc = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (misaligned) begin
            MisalignedExc = 1'b1;
          end else begin
            MemStall = 1'b1;
            state_d  = ACCESS;
            cnt_d    = CW'(LATENCY - 1);
          end
        end
      end
      ACCESS: begin
        MemStall = 1'b1;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      // DONE ignores the still-present request; upstream advances on this edge.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (Reset) begin
      MemStall      = 1'b0;
      MisalignedExc = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      wdata_q <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        idx_q   <= Address[AW+1:2];
        lane_q  <= Address[1:0];
        wdata_q <= WriteData;
        size_q  <= MemSize;
        uns_q   <= MemUnsigned;
        wr_q    <= MemWrite;
        // A simultaneous read+write is a store only.
        rd_q    <= MemRead & ~MemWrite;
      end
      if (fire && rd_q) rdata_q <= load_ext;
    end
  end

  assign cur_word = mem_q[idx_q];
  assign byte_v   = cur_word[8*lane_q +: 8];
  assign half_v   = lane_q[1] ? cur_word[31:16] : cur_word[15:0];

  always_comb begin
    load_ext = cur_word;
    case (size_q)
      2'b10:   load_ext = uns_q ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   load_ext = uns_q ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_ext = cur_word;
    endcase
  end

  // Read-modify-write keeps the unselected byte lanes intact.
  always_comb begin
    store_word = cur_word;
    case (size_q)
      2'b10: store_word[8*lane_q +: 8] = wdata_q[7:0];
      2'b01: begin
        if (lane_q[1]) store_word[31:16] = wdata_q[15:0];
        else           store_word[15:0]  = wdata_q[15:0];
      end
      default: store_word = wdata_q;
    endcase
  end

  // Array has no reset. An asynchronous Reset drops the FSM to IDLE, so a
  // pending store never reaches its commit edge.
  always_ff @(posedge Clk) begin
    if (fire && wr_q) mem_q[idx_q] <= store_word;
  end

  assign MemReadData = rdata_q;

endmodule

// File: tb/tb_data_memory_stage.sv
module tb_data_memory_stage;

  logic        Clk;
  logic        Reset;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemSize;
  logic        MemUnsigned;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] MemReadData;
  logic        MemStall;
  logic        MisalignedExc;

  int total;
  int bad;

  data_memory_stage #(.MEM_WORDS(1024), .LATENCY(2)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .MemSize(MemSize),
    .MemUnsigned(MemUnsigned),
    .Address(Address),
    .WriteData(WriteData),
    .MemReadData(MemReadData),
    .MemStall(MemStall),
    .MisalignedExc(MisalignedExc)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemSize     = 2'b00;
    MemUnsigned = 1'b0;
    Address     = 32'h0;
    WriteData   = 32'h0;
  endtask

  // Aligned access: request held through DONE, stall length checked,
  // MemReadData checked in the DONE cycle, then no re-trigger after DONE.
  task automatic access(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd);
    int n;
    n = 0;
    @(negedge Clk);
    MemRead = rd; MemWrite = wr; MemSize = sz; MemUnsigned = uns; Address = a; WriteData = wd;
    #1;
    while (MemStall && n < 20) begin
      n++;
      @(negedge Clk);
      #1;
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'd3);
    chk({tag, "_rdata"}, MemReadData, exp_rd);
    @(negedge Clk);
    idle_inputs();
    #1;
    chk({tag, "_no_retrigger"}, {31'b0, MemStall}, 32'd0);
  endtask

  task automatic misaligned(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
    @(negedge Clk);
    MemRead = rd; MemWrite = wr; MemSize = sz; MemUnsigned = 1'b0; Address = a; WriteData = wd;
    #1;
    chk({tag, "_exc"}, {31'b0, MisalignedExc}, 32'd1);
    chk({tag, "_stall"}, {31'b0, MemStall}, 32'd0);
    @(negedge Clk);
    idle_inputs();
    #1;
    chk({tag, "_exc_clear"}, {31'b0, MisalignedExc}, 32'd0);
    chk({tag, "_rdata_held"}, MemReadData, exp_rd);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    Reset = 1'b1;
    // Misaligned load present during reset must not raise anything.
    MemRead = 1'b1;
    Address = 32'h41;
    #1;
    chk("reset_rdata", MemReadData, 32'h0);
    chk("reset_stall", {31'b0, MemStall}, 32'd0);
    chk("reset_exc", {31'b0, MisalignedExc}, 32'd0);
    @(negedge Clk);
    idle_inputs();
    @(negedge Clk);
    Reset = 1'b0;

    // Word store then load.
    access("sw_10", 1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0);
    access("lw_10", 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);

    // Byte store into a known word, then sign/zero-extended byte loads.
    access("sw_20", 1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h11223344, 32'hDEADBEEF);
    access("sb_22", 1'b0, 1'b1, 2'b10, 1'b0, 32'h22, 32'hFFFFFFAB, 32'hDEADBEEF);
    access("lw_20", 1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h11AB3344);
    access("lb_22", 1'b1, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'hFFFFFFAB);
    access("lbu_22", 1'b1, 1'b0, 2'b10, 1'b1, 32'h22, 32'h0, 32'h000000AB);
    access("lb_20", 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h00000044);
    access("lbu_23", 1'b1, 1'b0, 2'b10, 1'b1, 32'h23, 32'h0, 32'h00000011);

    // Half store over zero, then half loads.
    access("sw_30", 1'b0, 1'b1, 2'b00, 1'b0, 32'h30, 32'h0, 32'h00000011);
    access("sh_32", 1'b0, 1'b1, 2'b01, 1'b0, 32'h32, 32'h12348001, 32'h00000011);
    access("lw_30", 1'b1, 1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 32'h80010000);
    access("lh_32", 1'b1, 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 32'hFFFF8001);
    access("lhu_32", 1'b1, 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 32'h00008001);
    access("lh_30", 1'b1, 1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 32'h00000000);

    // Misaligned requests.
    misaligned("mis_lw_41", 1'b1, 1'b0, 2'b00, 32'h41, 32'h0, 32'h00000000);
    access("sw_40", 1'b0, 1'b1, 2'b00, 1'b0, 32'h40, 32'hCAFEF00D, 32'h00000000);
    misaligned("mis_sh_43", 1'b0, 1'b1, 2'b01, 32'h43, 32'h0000FFFF, 32'h00000000);
    access("lw_40", 1'b1, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D);
    access("lbu_41", 1'b1, 1'b0, 2'b10, 1'b1, 32'h41, 32'h0, 32'h000000F0);
    misaligned("mis_lw11_62", 1'b1, 1'b0, 2'b11, 32'h62, 32'h0, 32'h000000F0);

    // Reset in the first ACCESS cycle of a store aborts it.
    access("sw_50_zero", 1'b0, 1'b1, 2'b00, 1'b0, 32'h50, 32'h0, 32'h000000F0);
    @(negedge Clk);
    MemWrite = 1'b1; MemSize = 2'b00; Address = 32'h50; WriteData = 32'h12345678;
    #1;
    chk("rst_mid_stall_c0", {31'b0, MemStall}, 32'd1);
    @(negedge Clk);
    #1;
    chk("rst_mid_stall_c1", {31'b0, MemStall}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("rst_mid_stall", {31'b0, MemStall}, 32'd0);
    chk("rst_mid_rdata", MemReadData, 32'h0);
    @(negedge Clk);
    idle_inputs();
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("rst_mid_idle_stall", {31'b0, MemStall}, 32'd0);
    access("lw_50", 1'b1, 1'b0, 2'b00, 1'b0, 32'h50, 32'h0, 32'h00000000);

    // Address wrap modulo 4 KiB.
    access("sw_1004", 1'b0, 1'b1, 2'b00, 1'b0, 32'h1004, 32'h5A5A5A5A, 32'h00000000);
    access("lw_4", 1'b1, 1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 32'h5A5A5A5A);

    // Read+write together is a store with no load result; size 11 is a word.
    access("rw_60", 1'b1, 1'b1, 2'b11, 1'b0, 32'h60, 32'h00000077, 32'h5A5A5A5A);
    access("lw11_60", 1'b1, 1'b0, 2'b11, 1'b1, 32'h60, 32'h0, 32'h00000077);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
